// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, arbiter state encoding and the
// default burst/timeout values also used by the uart_16550 configuration.
package uart_pkg;

   localparam int UART_DATA_W      = 8;
   localparam int ARB_MAX_BURST    = 16;
   localparam int ARB_IDLE_TIMEOUT = 32;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } uart_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first asserted request at or after ptr,
// wrapping at N. Shared by the UART arbiters.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      found  = 1'b0;
      idx    = '0;
      onehot = '0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[(int'(ptr) + i) % N]) begin
            found = 1'b1;
            idx   = IDX_W'((int'(ptr) + i) % N);
         end
      end
      onehot[idx] = found;
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing the UART TX FIFO push port between several
// byte-stream requesters; a grant is held for a whole message.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ARB_IDLE | no owner; pick next requester from rr_ptr (one bubble cycle)
//   ARB_LOCK | owner holds the TX path until last, burst limit, idle
//            | timeout or its enable drops
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int MAX_BURST    = ARB_MAX_BURST,
   parameter int IDLE_TIMEOUT = ARB_IDLE_TIMEOUT
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_en_i,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   input  logic [UART_DATA_W*NUM_REQ-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]             req_last_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   output logic                           tx_valid_o,
   output logic [UART_DATA_W-1:0]         tx_data_o,
   input  logic                           tx_ready_i,
   output logic [NUM_REQ-1:0]             grant_o,
   output logic                           busy_o
);

   localparam int         IDX_W    = $clog2(NUM_REQ);
   localparam logic [7:0] BURST_TC = 8'(MAX_BURST - 1);
   localparam logic [7:0] IDLE_TC  = 8'(IDLE_TIMEOUT - 1);

   uart_arb_state_t        state_q, state_d;
   logic [IDX_W-1:0]       owner_q, rr_ptr_q, rr_next, pick_idx;
   logic [NUM_REQ-1:0]     grant_q, pick_onehot;
   logic                   pick_found;
   logic [7:0]             beat_cnt_q, idle_tmr_q;
   logic                   tx_valid_q;
   logic [UART_DATA_W-1:0] tx_data_q, own_data;
   logic                   in_lock, own_en, own_valid, own_last, own_ready;
   logic                   xfer, rel;

   rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
      .req    (req_en_i & req_valid_i),
      .ptr    (rr_ptr_q),
      .found  (pick_found),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   assign in_lock   = (state_q == ARB_LOCK);
   assign own_en    = req_en_i[owner_q];
   assign own_valid = req_valid_i[owner_q];
   assign own_last  = req_last_i[owner_q];
   assign own_data  = req_data_i[{owner_q, 3'b000} +: UART_DATA_W];
   assign own_ready = in_lock & own_en & (~tx_valid_q | tx_ready_i);
   assign xfer      = own_ready & own_valid;
   assign rr_next   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

   // Idle timer counts down only while the owner has nothing to offer.
   assign rel = in_lock & ((xfer & (own_last | (beat_cnt_q == BURST_TC)))
                         | (~own_valid & (idle_tmr_q == 8'd0))
                         | ~own_en);

   always_comb begin
      req_ready_o          = '0;
      req_ready_o[owner_q] = own_ready;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ARB_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: if (pick_found) state_d = ARB_LOCK;
         ARB_LOCK: if (rel)        state_d = ARB_IDLE;
         default:                  state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_q    <= '0;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         idle_tmr_q <= IDLE_TC;
      end else if (!in_lock) begin
         if (pick_found) begin
            grant_q    <= pick_onehot;
            owner_q    <= pick_idx;
            beat_cnt_q <= '0;
            idle_tmr_q <= IDLE_TC;
         end
      end else begin
         if (xfer) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            idle_tmr_q <= IDLE_TC;
         end else if (!own_valid && idle_tmr_q != 8'd0) begin
            idle_tmr_q <= idle_tmr_q - 8'd1;
         end
         if (rel) begin
            grant_q  <= '0;
            rr_ptr_q <= rr_next;
         end
      end
   end

   // Output stage keeps draining after release; data only moves on a transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
      end else if (xfer) begin
         tx_valid_q <= 1'b1;
         tx_data_q  <= own_data;
      end else if (tx_ready_i) begin
         tx_valid_q <= 1'b0;
      end
   end

   assign tx_valid_o = tx_valid_q;
   assign tx_data_o  = tx_data_q;
   assign grant_o    = grant_q;
   assign busy_o     = in_lock | tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed message scenarios plus a randomized run
// scored against per-requester byte queues and a round-robin grant model.
module tb_uart_tx_arb;

   localparam int NR   = 4;
   localparam int MB   = 16;
   localparam int IT   = 32;
   localparam int MAXC = 8192;

   logic            clk = 1'b0;
   logic            rst;
   logic [NR-1:0]   req_en_i, req_valid_i, req_last_i, req_ready_o, grant_o;
   logic [8*NR-1:0] req_data_i;
   logic            tx_valid_o, tx_ready_i, busy_o;
   logic [7:0]      tx_data_o;

   uart_tx_arb #(.NUM_REQ(NR), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_en_i    (req_en_i),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_last_i  (req_last_i),
      .req_ready_o (req_ready_o),
      .tx_valid_o  (tx_valid_o),
      .tx_data_o   (tx_data_o),
      .tx_ready_i  (tx_ready_i),
      .grant_o     (grant_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc;

   logic [8:0]    mq [NR][$];
   logic [7:0]    exp_q[$], got_q[$], want[$];
   logic [NR-1:0] hold;
   logic          rnd_rdy, rnd_hold, rnd_en, tx_rdy;

   logic [NR-1:0] tr_g [MAXC], tr_rdy [MAXC], tr_req [MAXC], tr_acc [MAXC];
   logic          tr_txv [MAXC], tr_txr [MAXC], tr_busy [MAXC];
   logic [7:0]    tr_txd [MAXC];
   int            seg_own[$], seg_start[$], seg_len[$], seg_beats[$];

   function automatic int oh2idx(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic clear_bench();
      for (int k = 0; k < NR; k++) mq[k].delete();
      exp_q.delete();
      got_q.delete();
      want.delete();
      hold     = '0;
      rnd_rdy  = 1'b0;
      rnd_hold = 1'b0;
      rnd_en   = 1'b0;
      tx_rdy   = 1'b1;
      req_en_i = '1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_bench();
      req_valid_i = '0;
      req_data_i  = '0;
      req_last_i  = '0;
      tx_ready_i  = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      cyc = 0;
   endtask

   // One clock: drive requesters from their queues, record the cycle, advance.
   task automatic step();
      logic [8:0] e;
      if (rnd_hold) for (int k = 0; k < NR; k++) hold[k] = ($urandom_range(0, 7) == 0);
      if (rnd_en)
         for (int k = 0; k < NR; k++) if ($urandom_range(0, 39) == 0) req_en_i[k] = ~req_en_i[k];
      if (rnd_rdy) tx_rdy = ($urandom_range(0, 9) < 7);
      tx_ready_i = tx_rdy;
      for (int k = 0; k < NR; k++) begin
         if (mq[k].size() != 0 && !hold[k]) begin
            e = mq[k][0];
            req_valid_i[k]        = 1'b1;
            req_data_i[k*8 +: 8]  = e[7:0];
            req_last_i[k]         = e[8];
         end else begin
            req_valid_i[k]        = 1'b0;
            req_data_i[k*8 +: 8]  = 8'h00;
            req_last_i[k]         = 1'b0;
         end
      end
      #1;
      if (cyc < MAXC) begin
         tr_g[cyc]    = grant_o;
         tr_rdy[cyc]  = req_ready_o;
         tr_req[cyc]  = req_en_i & req_valid_i;
         tr_acc[cyc]  = req_valid_i & req_ready_o;
         tr_txv[cyc]  = tx_valid_o;
         tr_txr[cyc]  = tx_ready_i;
         tr_txd[cyc]  = tx_data_o;
         tr_busy[cyc] = busy_o;
      end
      for (int k = 0; k < NR; k++) begin
         if (req_valid_i[k] && req_ready_o[k]) begin
            exp_q.push_back(req_data_i[k*8 +: 8]);
            void'(mq[k].pop_front());
         end
      end
      if (tx_valid_o && tx_ready_i) got_q.push_back(tx_data_o);
      @(posedge clk);
      #1 cyc++;
   endtask

   task automatic analyze();
      int n;
      seg_own.delete(); seg_start.delete(); seg_len.delete(); seg_beats.delete();
      n = (cyc < MAXC) ? cyc : MAXC;
      for (int c = 0; c < n; c++) begin
         if (tr_g[c] != '0 && (c == 0 || tr_g[c-1] != tr_g[c])) begin
            seg_own.push_back(oh2idx(tr_g[c]));
            seg_start.push_back(c);
            seg_len.push_back(0);
            seg_beats.push_back(0);
         end
         if (tr_g[c] != '0) begin
            seg_len[seg_len.size()-1]     = seg_len[seg_len.size()-1] + 1;
            seg_beats[seg_beats.size()-1] = seg_beats[seg_beats.size()-1] + ((tr_acc[c] != '0) ? 1 : 0);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req_en_i = '1; req_valid_i = '1; req_last_i = '0;
      req_data_i = 32'hA5A5_A5A5; tx_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (tx_valid_o !== 1'b0) begin bad++; $display("FAIL reset_txv got=%b want=0", tx_valid_o); end
      total++; if (tx_data_o !== 8'h00) begin bad++; $display("FAIL reset_txd got=%h want=00", tx_data_o); end
      total++; if (grant_o !== 4'h0) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant_o); end
      total++; if (req_ready_o !== 4'h0) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready_o); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
      req_valid_i = '0;
   endtask

   task automatic test_single();
      do_reset();
      mq[0].push_back({1'b0, 8'h41});
      mq[0].push_back({1'b0, 8'h42});
      mq[0].push_back({1'b1, 8'h43});
      repeat (7) step();
      total++; if (tr_g[0] !== 4'b0000) begin bad++; $display("FAIL single_g0 got=%b want=0000", tr_g[0]); end
      for (int c = 1; c <= 3; c++) begin
         total++; if (tr_g[c] !== 4'b0001) begin bad++; $display("FAIL single_grant c=%0d got=%b want=0001", c, tr_g[c]); end
      end
      total++; if (tr_g[4] !== 4'b0000) begin bad++; $display("FAIL single_g4 got=%b want=0000", tr_g[4]); end
      for (int c = 2; c <= 4; c++) begin
         total++;
         if (tr_txv[c] !== 1'b1 || tr_txd[c] !== 8'(8'h41 + c - 2)) begin
            bad++; $display("FAIL single_tx c=%0d got=%b/%h want=1/%h", c, tr_txv[c], tr_txd[c], 8'(8'h41 + c - 2));
         end
      end
      total++; if (tr_txv[5] !== 1'b0 || tr_busy[5] !== 1'b0) begin bad++; $display("FAIL single_drain got=%b/%b want=0/0", tr_txv[5], tr_busy[5]); end
      // pointer now at 1: req1 must win over req0
      mq[0].push_back({1'b1, 8'h50});
      mq[1].push_back({1'b1, 8'h51});
      repeat (8) step();
      analyze();
      total++;
      if (seg_own.size() != 3) begin bad++; $display("FAIL single_segs got=%0d want=3", seg_own.size()); end
      else if (seg_own[1] != 1 || seg_own[2] != 0) begin
         bad++; $display("FAIL single_rrptr got=%0d,%0d want=1,0", seg_own[1], seg_own[2]);
      end
      want = '{8'h41, 8'h42, 8'h43, 8'h51, 8'h50};
      total++;
      if (got_q != want) begin bad++; $display("FAIL single_stream got=%p want=%p", got_q, want); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int k = 0; k < NR; k++) begin
         mq[k].push_back({1'b0, 8'(k*16)});
         mq[k].push_back({1'b1, 8'(k*16 + 1)});
      end
      mq[0].push_back({1'b0, 8'h08});
      mq[0].push_back({1'b1, 8'h09});
      repeat (20) step();
      analyze();
      total++;
      if (seg_own.size() != 5) begin
         bad++; $display("FAIL b2b_segs got=%0d want=5", seg_own.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            total++;
            if (seg_own[i] != i % NR || seg_len[i] != 2 || seg_start[i] != 1 + 3*i) begin
               bad++; $display("FAIL b2b_seg%0d got=own%0d/len%0d/at%0d want=own%0d/len2/at%0d",
                               i, seg_own[i], seg_len[i], seg_start[i], i % NR, 1 + 3*i);
            end
         end
      end
      want = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h08, 8'h09};
      total++;
      if (got_q != want) begin bad++; $display("FAIL b2b_stream got=%p want=%p", got_q, want); end
   endtask

   task automatic test_burst();
      do_reset();
      for (int i = 0; i < 20; i++) mq[1].push_back({1'b0, 8'(8'h80 + i)});
      mq[2].push_back({1'b0, 8'hA0});
      mq[2].push_back({1'b1, 8'hA1});
      repeat (70) step();
      analyze();
      total++;
      if (seg_own.size() != 3) begin
         bad++; $display("FAIL burst_segs got=%0d want=3", seg_own.size());
      end else begin
         total++;
         if (seg_own[0] != 1 || seg_beats[0] != MB || seg_len[0] != MB) begin
            bad++; $display("FAIL burst_first got=own%0d/beats%0d/len%0d want=own1/beats16/len16", seg_own[0], seg_beats[0], seg_len[0]);
         end
         total++;
         if (seg_own[1] != 2 || seg_start[1] != seg_start[0] + MB + 1) begin
            bad++; $display("FAIL burst_second got=own%0d/at%0d want=own2/at%0d", seg_own[1], seg_start[1], seg_start[0] + MB + 1);
         end
         total++;
         if (seg_own[2] != 1 || seg_beats[2] != 4 || seg_len[2] != 4 + IT) begin
            bad++; $display("FAIL burst_third got=own%0d/beats%0d/len%0d want=own1/beats4/len%0d", seg_own[2], seg_beats[2], seg_len[2], 4 + IT);
         end
      end
      want.delete();
      for (int i = 0; i < 16; i++) want.push_back(8'(8'h80 + i));
      want.push_back(8'hA0); want.push_back(8'hA1);
      for (int i = 16; i < 20; i++) want.push_back(8'(8'h80 + i));
      total++;
      if (got_q != want) begin bad++; $display("FAIL burst_stream got=%p want=%p", got_q, want); end
   endtask

   task automatic test_timeout();
      do_reset();
      mq[2].push_back({1'b0, 8'hC5});
      repeat (45) step();
      analyze();
      total++; if (tr_g[1] !== 4'b0100) begin bad++; $display("FAIL tmo_grant got=%b want=0100", tr_g[1]); end
      total++; if (tr_g[33] !== 4'b0100) begin bad++; $display("FAIL tmo_hold got=%b want=0100", tr_g[33]); end
      total++; if (tr_g[34] !== 4'b0000) begin bad++; $display("FAIL tmo_release got=%b want=0000", tr_g[34]); end
      total++;
      if (seg_len.size() != 1 || seg_len[0] != 1 + IT) begin
         bad++; $display("FAIL tmo_len got=%0d segs want=1 seg len %0d", seg_len.size(), 1 + IT);
      end
      total++; if (got_q.size() != 1) begin bad++; $display("FAIL tmo_bytes got=%0d want=1", got_q.size()); end
   endtask

   task automatic test_stall();
      int n, s0;
      do_reset();
      for (int i = 0; i < 6; i++) mq[0].push_back({(i == 5), 8'(8'h10 + i)});
      n = 0;
      while (exp_q.size() < 3 && n < 20) begin step(); n++; end
      total++; if (exp_q.size() != 3) begin bad++; $display("FAIL stall_setup got=%0d want=3", exp_q.size()); end
      tx_rdy = 1'b0;
      s0 = cyc;
      repeat (40) step();
      tx_rdy = 1'b1;
      repeat (15) step();
      for (int c = s0; c < s0 + 40; c++) begin
         total++;
         if (tr_rdy[c] !== 4'b0000 || tr_txv[c] !== 1'b1 || tr_txd[c] !== 8'h12 || tr_g[c] !== 4'b0001) begin
            bad++; $display("FAIL stall_hold c=%0d got=rdy%b/v%b/d%h/g%b want=rdy0000/v1/d12/g0001",
                            c, tr_rdy[c], tr_txv[c], tr_txd[c], tr_g[c]);
         end
      end
      analyze();
      total++;
      if (seg_own.size() != 1 || seg_beats[0] != 6) begin
         bad++; $display("FAIL stall_segs got=%0d segs want=1 seg of 6 beats", seg_own.size());
      end
      want = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      total++;
      if (got_q != want) begin bad++; $display("FAIL stall_stream got=%p want=%p", got_q, want); end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      mq[1].push_back({1'b1, 8'h61});
      repeat (5) step();
      for (int i = 0; i < 8; i++) mq[2].push_back({(i == 7), 8'(8'h70 + i)});
      n = 0;
      while (!(tx_valid_o && grant_o == 4'b0100) && n < 20) begin step(); n++; end
      total++; if (!(tx_valid_o && grant_o == 4'b0100)) begin bad++; $display("FAIL rstmid_setup got=v%b/g%b want=v1/g0100", tx_valid_o, grant_o); end
      #2 rst = 1'b0;
      #1;
      total++;
      if (tx_valid_o !== 1'b0 || tx_data_o !== 8'h00 || grant_o !== 4'b0000 || req_ready_o !== 4'b0000 || busy_o !== 1'b0) begin
         bad++; $display("FAIL rstmid_async got=v%b/d%h/g%b/r%b/b%b want=all zero", tx_valid_o, tx_data_o, grant_o, req_ready_o, busy_o);
      end
      clear_bench();
      req_valid_i = '0;
      mq[2].push_back({1'b1, 8'h77});
      mq[0].push_back({1'b1, 8'h07});
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      cyc = 0;
      repeat (10) step();
      analyze();
      total++;
      if (seg_own.size() == 0 || seg_own[0] != 0) begin
         bad++; $display("FAIL rstmid_first got=%0d want=0", (seg_own.size() == 0) ? -1 : seg_own[0]);
      end
      want = '{8'h07, 8'h77};
      total++;
      if (got_q != want) begin bad++; $display("FAIL rstmid_stream got=%p want=%p", got_q, want); end
   endtask

   task automatic test_random();
      int n, nbytes, len, idx, ptr, lim;
      logic [NR-1:0] exp_g;
      do_reset();
      nbytes = 0;
      for (int k = 0; k < NR; k++) begin
         for (int m = 0; m < 4; m++) begin
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) mq[k].push_back({(i == len - 1), 8'($urandom)});
            nbytes += len;
         end
      end
      rnd_rdy = 1'b1; rnd_hold = 1'b1; rnd_en = 1'b1;
      n = 0;
      while ((mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) != 0 && n < 1500) begin step(); n++; end
      rnd_hold = 1'b0; rnd_en = 1'b0; hold = '0; req_en_i = '1;
      while (((mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) != 0
              || got_q.size() < exp_q.size() || tx_valid_o) && n < 4000) begin
         step(); n++;
      end
      repeat (3) step();
      total++; if (n >= 4000) begin bad++; $display("FAIL rand_timeout got=%0d cycles want<4000", n); end
      total++; if (exp_q.size() != nbytes) begin bad++; $display("FAIL rand_accepted got=%0d want=%0d", exp_q.size(), nbytes); end
      total++; if (got_q.size() != nbytes) begin bad++; $display("FAIL rand_pushed got=%0d want=%0d", got_q.size(), nbytes); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
      ptr = 0;
      lim = (cyc < MAXC) ? cyc : MAXC;
      for (int c = 1; c < lim; c++) begin
         total++;
         if ($countones(tr_g[c]) > 1 || (tr_rdy[c] & ~tr_g[c]) != '0) begin
            bad++; $display("FAIL rand_onehot c=%0d got=g%b/r%b want=onehot0, ready within grant", c, tr_g[c], tr_rdy[c]);
         end
         if (tr_g[c-1] == '0) begin
            exp_g = '0;
            for (int i = 0; i < NR; i++) begin
               idx = (ptr + i) % NR;
               if (exp_g == '0 && tr_req[c-1][idx]) exp_g[idx] = 1'b1;
            end
            total++;
            if (tr_g[c] !== exp_g) begin bad++; $display("FAIL rand_rr c=%0d got=%b want=%b", c, tr_g[c], exp_g); end
         end else if (tr_g[c] != '0) begin
            total++;
            if (tr_g[c] !== tr_g[c-1]) begin bad++; $display("FAIL rand_switch c=%0d got=%b want=%b", c, tr_g[c], tr_g[c-1]); end
         end else begin
            ptr = (oh2idx(tr_g[c-1]) + 1) % NR;
         end
         if (tr_txv[c-1] && !tr_txr[c-1]) begin
            total++;
            if (tr_txv[c] !== 1'b1 || tr_txd[c] !== tr_txd[c-1]) begin
               bad++; $display("FAIL rand_hold c=%0d got=%b/%h want=1/%h", c, tr_txv[c], tr_txd[c], tr_txd[c-1]);
            end
         end
         total++;
         if (tr_busy[c] !== ((tr_g[c] != '0) || tr_txv[c])) begin
            bad++; $display("FAIL rand_busy c=%0d got=%b want=%b", c, tr_busy[c], ((tr_g[c] != '0) || tr_txv[c]));
         end
      end
      analyze();
      for (int i = 0; i < seg_beats.size(); i++) begin
         total++;
         if (seg_beats[i] > MB) begin bad++; $display("FAIL rand_burst seg%0d got=%0d want<=%0d", i, seg_beats[i], MB); end
      end
   endtask

   initial begin
      rst = 1'b0;
      req_en_i = '0; req_valid_i = '0; req_last_i = '0; req_data_i = '0;
      tx_ready_i = 1'b0;
      clear_bench();
      cyc = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_burst();
      test_timeout();
      test_stall();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
